reg_scoreboard: RTL and testbench

- Issue controller in front of the 32x64 register file.
- Tracks pending destination writes per architectural register and stalls decode on RAW/WAW hazards.
- Generates the register file's read-enable pulse and clears pending bits on writeback.
- Provides a drain sequence so a register dump (print request) happens only after all in-flight writes have retired.

---
 rtl/sb_pkg.sv | 10 +
 rtl/sb_hazard_check.sv | 21 ++
 rtl/reg_scoreboard.sv | 66 ++++++
 tb/tb_reg_scoreboard.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared types and constants for the register scoreboard
package sb_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W = 3;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} sb_state_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/sb_hazard_check.sv
// sb_hazard_check: RAW/WAW/capacity hazard detection from registered scoreboard state
module sb_hazard_check
  import sb_pkg::*;
(
  input  logic [NUM_REGS-1:0] busy_vec,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic                uses_rs2,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                writes_rd,
  input  logic [CNT_W-1:0]    inflight,
  output logic                hazard
);
  logic [NUM_REGS-1:0] busy;
  logic wr;
  // x0 is masked so it can never stall a reader or a writer
  assign busy = busy_vec & ~NUM_REGS'(1);
  assign wr = writes_rd & (rd != ZERO_REG);
  assign hazard = busy[rs1] | (uses_rs2 & busy[rs2]) |
                  (wr & (busy[rd] | (inflight == CNT_W'(MAX_INFLIGHT))));
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue controller tracking pending register writes, with drain-before-dump sequencing
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_uses_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_writes_rd,
  output logic                issue_ready,
  output logic                rf_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                drain_req,
  output logic                drain_done,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    inflight,
  output logic                wb_err
);
  sb_state_t state, state_nxt;
  logic hazard, set, clr;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  sb_hazard_check u_hazard (
    .busy_vec (busy_vec),
    .rs1      (issue_rs1),
    .rs2      (issue_rs2),
    .uses_rs2 (issue_uses_rs2),
    .rd       (issue_rd),
    .writes_rd(issue_writes_rd),
    .inflight (inflight),
    .hazard   (hazard)
  );

  // a drain request blocks issue in the very cycle it is raised
  assign issue_ready = (state == RUN) & ~drain_req & ~hazard;
  assign rf_en = issue_valid & issue_ready;
  assign set = rf_en & issue_writes_rd & (issue_rd != ZERO_REG);
  assign clr = wb_valid & (wb_rd != ZERO_REG) & busy_vec[wb_rd];
  assign set_mask = set ? (NUM_REGS'(1) << issue_rd) : '0;
  assign clr_mask = clr ? (NUM_REGS'(1) << wb_rd) : '0;

  always_comb
    state_nxt = (state == RUN)   ? (drain_req ? DRAIN : RUN) :
                (state == DRAIN) ? ((inflight == '0) ? DONE : DRAIN) :
                (drain_req ? DONE : RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      busy_vec   <= '0;
      inflight   <= '0;
      wb_err     <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy_vec   <= (busy_vec & ~clr_mask) | set_mask;
      inflight   <= inflight + CNT_W'(set) - CNT_W'(clr);
      wb_err     <= wb_err | (wb_valid & ~clr);
      drain_done <= (state == DRAIN) & (inflight == '0);
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus with a queued-expectation scoreboard checked by a monitor
module tb_reg_scoreboard;
  import sb_pkg::*;
  logic clk = 0, reset = 1;
  logic issue_valid = 0, issue_uses_rs2 = 0, issue_writes_rd = 0;
  logic [ADDR_W-1:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0;
  logic wb_valid = 0, drain_req = 0;
  logic issue_ready, rf_en, drain_done, wb_err;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0] inflight;
  int cyc = 0, total = 0, bad = 0;
  string qn[$];
  int qc[$], qk[$];
  logic [31:0] qv[$];

  localparam int K_RDY = 0, K_EN = 1, K_BUSY = 2, K_INF = 3, K_ERR = 4, K_DONE = 5;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_uses_rs2(issue_uses_rs2), .issue_rd(issue_rd),
    .issue_writes_rd(issue_writes_rd), .issue_ready(issue_ready), .rf_en(rf_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req), .drain_done(drain_done),
    .busy_vec(busy_vec), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int k);
    return k == K_RDY  ? 32'(issue_ready) :
           k == K_EN   ? 32'(rf_en) :
           k == K_BUSY ? busy_vec :
           k == K_INF  ? 32'(inflight) :
           k == K_ERR  ? 32'(wb_err) : 32'(drain_done);
  endfunction

  always @(negedge clk) begin
    while (qc.size() > 0 && qc[0] <= cyc) begin
      string n;
      int c, k;
      logic [31:0] v, a;
      n = qn.pop_front(); c = qc.pop_front(); k = qk.pop_front(); v = qv.pop_front();
      a = sample(k);
      total++;
      if (c != cyc || a !== v) begin
        bad++;
        $display("FAIL %s (cycle %0d): got %0h want %0h", n, c, a, v);
      end
    end
  end

  task automatic want(string n, int k, logic [31:0] v);
    qn.push_back(n); qc.push_back(cyc); qk.push_back(k); qv.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic v, int rs1, int rs2, logic u2, int rd, logic wr);
    issue_valid = v; issue_rs1 = ADDR_W'(rs1); issue_rs2 = ADDR_W'(rs2);
    issue_uses_rs2 = u2; issue_rd = ADDR_W'(rd); issue_writes_rd = wr;
  endtask

  task automatic wb(logic v, int rd);
    wb_valid = v; wb_rd = ADDR_W'(rd);
  endtask

  initial begin
    repeat (2) step();
    reset = 0;
    issue(0, 0, 0, 0, 0, 0); wb(0, 0);
    want("rst_busy", K_BUSY, 0); want("rst_inf", K_INF, 0);
    want("rst_err", K_ERR, 0); want("rst_done", K_DONE, 0); want("rst_ready", K_RDY, 1);
    step(); issue(1, 1, 2, 1, 5, 1);
    want("raw_fire", K_RDY, 1); want("raw_fire_en", K_EN, 1);
    step(); issue(1, 5, 0, 0, 0, 0); wb(1, 5);
    want("raw_stall", K_RDY, 0); want("raw_stall_en", K_EN, 0);
    want("raw_busy", K_BUSY, 32'h20); want("raw_inf", K_INF, 1);
    step(); wb(0, 0);
    want("raw_release", K_RDY, 1); want("raw_release_en", K_EN, 1);
    want("raw_cleared", K_BUSY, 0); want("raw_inf0", K_INF, 0);
    step(); issue(1, 0, 0, 0, 7, 1);
    want("imm_setup", K_RDY, 1);
    step(); issue(1, 1, 7, 0, 0, 0);
    want("imm_busy7", K_BUSY, 32'h80); want("imm_ready", K_RDY, 1);
    step(); issue(1, 1, 7, 1, 0, 0); wb(1, 7);
    want("rs2_stall", K_RDY, 0);
    step(); issue(0, 0, 0, 0, 0, 0); wb(0, 0);
    want("imm_clear", K_BUSY, 0); want("imm_inf", K_INF, 0);
    step(); issue(1, 0, 0, 0, 0, 1);
    want("x0_ready", K_RDY, 1);
    step(); issue(0, 0, 0, 0, 0, 0);
    want("x0_busy", K_BUSY, 0); want("x0_inf", K_INF, 0); want("x0_err", K_ERR, 0);
    for (int r = 1; r <= 4; r++) begin
      step(); issue(1, 0, 0, 0, r, 1);
      want("cap_fill", K_RDY, 1);
    end
    step(); issue(1, 0, 0, 0, 6, 1); wb(1, 2);
    want("cap_full", K_RDY, 0); want("cap_inf4", K_INF, 4); want("cap_busy", K_BUSY, 32'h1E);
    step(); wb(0, 0);
    want("cap_after_wb", K_RDY, 1); want("cap_inf3", K_INF, 3); want("cap_busy2", K_BUSY, 32'h1A);
    step(); issue(0, 0, 0, 0, 0, 0); wb(1, 1);
    want("cap_refill", K_INF, 4);
    step(); issue(1, 0, 0, 0, 9, 1); wb(1, 3);
    want("sim_pre_busy", K_BUSY, 32'h58); want("sim_ready", K_RDY, 1);
    step(); issue(0, 0, 0, 0, 0, 0); wb(1, 12);
    want("sim_busy", K_BUSY, 32'h250); want("sim_inf", K_INF, 3); want("sim_err0", K_ERR, 0);
    step(); wb(1, 4);
    want("err_set", K_ERR, 1); want("err_busy", K_BUSY, 32'h250); want("err_inf", K_INF, 3);
    step(); wb(0, 0); issue(1, 1, 0, 0, 0, 0); drain_req = 1;
    want("drain_inf2", K_INF, 2); want("err_sticky", K_ERR, 1);
    want("drain_block", K_RDY, 0); want("drain_block_en", K_EN, 0);
    step(); wb(1, 6);
    want("drain_wait_rdy", K_RDY, 0); want("drain_wait_done", K_DONE, 0);
    step(); wb(1, 9);
    want("drain_inf1", K_INF, 1); want("drain_wait_done2", K_DONE, 0);
    step(); wb(0, 0);
    want("drain_inf0", K_INF, 0); want("drain_not_yet", K_DONE, 0);
    step(); drain_req = 0;
    want("drain_pulse", K_DONE, 1); want("drain_pulse_rdy", K_RDY, 0);
    step(); issue(1, 1, 0, 0, 8, 1);
    want("drain_once", K_DONE, 0); want("run_again", K_RDY, 1);
    step(); issue(1, 8, 0, 0, 0, 0); drain_req = 1;
    want("pre_rst_busy", K_BUSY, 32'h100); want("pre_rst_rdy", K_RDY, 0);
    step(); drain_req = 0; reset = 1;
    want("in_drain_rdy", K_RDY, 0);
    step(); reset = 0;
    want("rst_mid_busy", K_BUSY, 0); want("rst_mid_inf", K_INF, 0);
    want("rst_mid_err", K_ERR, 0); want("rst_mid_rdy", K_RDY, 1); want("rst_mid_en", K_EN, 1);
    for (int i = 0; i < 10 && qc.size() > 0; i++) step();
    if (qc.size() > 0) begin
      bad += qc.size();
      $display("FAIL drain_queue: got %0d unchecked want 0", qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
